// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider controller.
package clk_div_pkg;

    localparam int BASE_FREQ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    // Half-period limit that yields the requested output frequency.
    function automatic int lim_from_freq(input int freq);
        return BASE_FREQ / (2 * freq) - 1;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter, output toggle flop and per-period tick.
module clk_div_core #(
    parameter int DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_a_p,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] lim,
    output logic             clk_out,
    output logic             tick,
    output logic             fall,
    output logic             clk_lo
);
    logic [DIV_W-1:0] cnt;
    logic             at_lim;

    assign at_lim = (cnt == lim);
    assign fall   = en & at_lim & clk_out;
    assign clk_lo = ~clk_out;

    // Dropping en parks the divider low with the counter cleared.
    always_ff @(posedge clk_in) begin
        if (rst_a_p || !en) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= at_lim & ~clk_out;
            if (at_lim) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else if (load) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Start/stop sequencing and period-boundary divisor updates for the clock divider.
// state    | meaning
// IDLE     | clk_out held low, counter at 0
// RUN      | dividing
// STOPPING | dividing until the next falling edge, then IDLE
module clk_div_ctrl #(
    parameter int BASE_FREQ    = 50_000_000,
    parameter int DIV_W        = 16,
    parameter int DEFAULT_FREQ = 1_000_000
) (
    input  logic             clk_in,
    input  logic             rst_a_p,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_lim,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [DIV_W-1:0] cur_lim
);
    import clk_div_pkg::*;

    localparam logic [DIV_W-1:0] DEFAULT_LIM = DIV_W'(BASE_FREQ / (2 * DEFAULT_FREQ) - 1);

    state_e           state;
    state_e           state_nx;
    logic [DIV_W-1:0] pend_lim;
    logic             pend_valid;
    logic             core_en;
    logic             core_fall;
    logic             core_lo;
    logic             go_idle_lo;
    logic             apply;
    logic             xfer;

    // Stopping in the low phase truncates it; the core must not rise on that edge.
    assign go_idle_lo = (state == RUN) & stop & core_lo;
    assign core_en    = (state != IDLE) & ~go_idle_lo;
    assign running    = (state != IDLE);
    assign cfg_ready  = ~pend_valid;
    assign xfer       = cfg_valid & cfg_ready;
    assign apply      = pend_valid & (core_fall | go_idle_lo | (state == IDLE));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start & ~stop) state_nx = RUN;
            RUN:      if (stop) state_nx = core_lo ? IDLE : STOPPING;
            STOPPING: begin
                if (start & ~stop)  state_nx = RUN;
                else if (core_fall) state_nx = IDLE;
            end
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_a_p) begin
            state      <= IDLE;
            cur_lim    <= DEFAULT_LIM;
            pend_lim   <= '0;
            pend_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if (apply) begin
                cur_lim    <= pend_lim;
                pend_valid <= 1'b0;
            end else if (xfer) begin
                if (state == IDLE) begin
                    cur_lim <= cfg_lim;
                end else begin
                    pend_lim   <= cfg_lim;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    clk_div_core #(.DIV_W(DIV_W)) u_core (
        .clk_in  (clk_in),
        .rst_a_p (rst_a_p),
        .en      (core_en),
        .load    (apply),
        .lim     (cur_lim),
        .clk_out (clk_out),
        .tick    (tick),
        .fall    (core_fall),
        .clk_lo  (core_lo)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: divisor table plus start/stop/config corner sequences.
module tb_clk_div_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_a_p;
    logic        start;
    logic        stop;
    logic        cfg_valid;
    logic [15:0] cfg_lim;
    logic        cfg_ready;
    logic        clk_out;
    logic        tick;
    logic        running;
    logic [15:0] cur_lim;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    typedef struct {
        logic [15:0] lim;
        int          first;
        int          period;
        int          high;
    } vec_t;

    vec_t vecs[5];

    clk_div_ctrl dut (
        .clk_in    (clk_in),
        .rst_a_p   (rst_a_p),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_lim   (cfg_lim),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running),
        .cur_lim   (cur_lim)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 500);
        if (tick !== 1'b1) n = -1;
    endtask

    task automatic wait_clk(input logic lvl, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (clk_out !== lvl && n < 500);
        if (clk_out !== lvl) n = -1;
    endtask

    // Scoreboard: pop one expected tick gap per observed tick.
    task automatic check_gaps(input string name, input int k);
        int n;
        for (int i = 0; i < k; i++) begin
            wait_tick(n);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s scoreboard empty actual=%0d required=none", name, n);
            end else begin
                chk(name, n, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        logic seen;

        vecs[0] = '{lim: 16'd24, first: 25, period: 50, high: 25};
        vecs[1] = '{lim: 16'd0,  first: 1,  period: 2,  high: 1};
        vecs[2] = '{lim: 16'd1,  first: 2,  period: 4,  high: 2};
        vecs[3] = '{lim: 16'd4,  first: 5,  period: 10, high: 5};
        vecs[4] = '{lim: 16'd9,  first: 10, period: 20, high: 10};

        rst_a_p = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_lim = '0;
        step(); step();
        rst_a_p = 1'b0;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_running", running, 0);
        chk("rst_cur_lim", cur_lim, 24);
        chk("rst_cfg_ready", cfg_ready, 1);

        for (int v = 0; v < 5; v++) begin
            cfg_valid = 1'b1; cfg_lim = vecs[v].lim;
            step();
            cfg_valid = 1'b0;
            chk("idle_cfg_lim", cur_lim, vecs[v].lim);
            chk("idle_cfg_ready", cfg_ready, 1);
            start = 1'b1;
            step();
            start = 1'b0;
            chk("run_entry", running, 1);
            exp_q.push_back(vecs[v].first);
            exp_q.push_back(vecs[v].period);
            exp_q.push_back(vecs[v].period);
            check_gaps("tick_gap", 3);
            cnt = 1;
            step();
            while (clk_out === 1'b1 && cnt < 500) begin
                cnt++;
                step();
            end
            chk("high_len", cnt, vecs[v].high);
            stop = 1'b1;
            step();
            stop = 1'b0;
            chk("stop_lo_running", running, 0);
            chk("stop_lo_clk", clk_out, 0);
            chk("stop_lo_tick", tick, 0);
        end

        // Config offered mid-high phase waits for the falling edge.
        rst_a_p = 1'b1; step(); rst_a_p = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        exp_q.push_back(25);
        check_gaps("default_first", 1);
        repeat (5) step();
        cfg_valid = 1'b1; cfg_lim = 16'd4;
        step();
        cfg_valid = 1'b0;
        chk("pend_ready_low", cfg_ready, 0);
        chk("pend_lim_held", cur_lim, 24);
        seen = 1'b0;
        cnt = 0;
        while (clk_out === 1'b1 && cnt < 500) begin
            if (cfg_ready !== 1'b0) seen = 1'b1;
            step();
            cnt++;
        end
        chk("pend_ready_hold", seen, 0);
        chk("pend_applied_lim", cur_lim, 4);
        chk("pend_applied_ready", cfg_ready, 1);
        exp_q.push_back(5);
        exp_q.push_back(10);
        exp_q.push_back(10);
        check_gaps("new_lim_gap", 3);

        // Stop in the high phase finishes the pulse.
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_hi_running", running, 1);
        chk("stop_hi_clk", clk_out, 1);
        seen = 1'b0;
        n = 0;
        while (clk_out === 1'b1 && n < 500) begin
            if (running !== 1'b1) seen = 1'b1;
            step();
            n++;
        end
        chk("stop_hi_len", n, 4);
        chk("stop_hi_run_held", seen, 0);
        chk("stop_hi_idle", running, 0);

        start = 1'b1; stop = 1'b1;
        step(); step();
        chk("start_stop_idle_run", running, 0);
        chk("start_stop_idle_clk", clk_out, 0);
        start = 1'b0; stop = 1'b0;

        // Start during STOPPING resumes without disturbing the period.
        start = 1'b1; step(); start = 1'b0;
        exp_q.push_back(5);
        check_gaps("resume_first", 1);
        stop = 1'b1; step(); stop = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("resume_running", running, 1);
        wait_tick(n);
        chk("resume_gap", n + 2, 10);
        exp_q.push_back(10);
        check_gaps("resume_period", 1);

        // Config accepted on the falling edge waits one more period.
        repeat (4) step();
        cfg_valid = 1'b1; cfg_lim = 16'd2;
        step();
        cfg_valid = 1'b0;
        chk("fall_cfg_clk", clk_out, 0);
        chk("fall_cfg_ready", cfg_ready, 0);
        chk("fall_cfg_lim_old", cur_lim, 4);
        exp_q.push_back(5);
        check_gaps("fall_cfg_old_gap", 1);
        wait_clk(1'b0, n);
        chk("fall_cfg_high", n, 5);
        chk("fall_cfg_lim_new", cur_lim, 2);
        chk("fall_cfg_ready_back", cfg_ready, 1);
        exp_q.push_back(3);
        check_gaps("fall_cfg_new_gap", 1);

        // Reset during high phase with a pending config.
        cfg_valid = 1'b1; cfg_lim = 16'd7;
        step();
        cfg_valid = 1'b0;
        chk("rst_mid_pending", cfg_ready, 0);
        chk("rst_mid_high", clk_out, 1);
        rst_a_p = 1'b1; step(); rst_a_p = 1'b0;
        chk("rst_mid_clk", clk_out, 0);
        chk("rst_mid_tick", tick, 0);
        chk("rst_mid_running", running, 0);
        chk("rst_mid_lim", cur_lim, 24);
        chk("rst_mid_ready", cfg_ready, 1);
        step();
        chk("rst_mid_lim_after", cur_lim, 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
